// File: rtl/sdrio_dir_sched.sv
// Direction scheduler for a 4:1 serialized bidirectional IO: arbitrates read/write bursts
// on frame boundaries and decodes pad enable, termination and capture strobes from state.
module sdrio_dir_sched #(
  parameter int PRE_FRAMES  = 1,
  parameter int TURN_FRAMES = 2
) (
  input  logic       geclk_ol,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [2:0] wr_len,
  input  logic       rd_req,
  input  logic [2:0] rd_len,
  output logic       wr_gnt,
  output logic       rd_gnt,
  output logic [3:0] t_nib,
  output logic       odt_ctrl,
  output logic       rd_capture,
  output logic       update_ol,
  output logic [1:0] phase,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WPRE  = 3'd1,
    WDATA = 3'd2,
    WPOST = 3'd3,
    RDATA = 3'd4,
    TURN  = 3'd5
  } state_t;

  // TURN reuses the frame counter, loaded with frames-minus-one like a burst
  localparam logic [2:0] TURN_LOAD = 3'((TURN_FRAMES > 0) ? TURN_FRAMES - 1 : 0);

  state_t     state, state_nxt, after_burst;
  logic [1:0] ph;
  logic [2:0] fcnt, fcnt_nxt;
  logic       last_dir, last_dir_nxt;  // 1 = last grant was a write
  logic       frame_end;

  assign frame_end   = (ph == 2'd3);
  assign after_burst = (TURN_FRAMES > 0) ? TURN : IDLE;

  always_ff @(posedge geclk_ol or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ph       <= 2'd0;
      fcnt     <= 3'd0;
      last_dir <= 1'b0;
    end else begin
      state    <= state_nxt;
      ph       <= ph + 2'd1;
      fcnt     <= fcnt_nxt;
      last_dir <= last_dir_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fcnt_nxt     = fcnt;
    last_dir_nxt = last_dir;
    wr_gnt       = 1'b0;
    rd_gnt       = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (wr_req && (!rd_req || !last_dir)) begin
            wr_gnt       = 1'b1;
            last_dir_nxt = 1'b1;
            fcnt_nxt     = wr_len;
            state_nxt    = (PRE_FRAMES == 1) ? WPRE : WDATA;
          end else if (rd_req) begin
            rd_gnt       = 1'b1;
            last_dir_nxt = 1'b0;
            fcnt_nxt     = rd_len;
            state_nxt    = RDATA;
          end
        end
        WPRE: state_nxt = WDATA;
        WDATA: begin
          if (fcnt == 3'd0) state_nxt = WPOST;
          else              fcnt_nxt  = fcnt - 3'd1;
        end
        WPOST: begin
          state_nxt = after_burst;
          fcnt_nxt  = TURN_LOAD;
        end
        RDATA: begin
          if (fcnt == 3'd0) begin
            state_nxt = after_burst;
            fcnt_nxt  = TURN_LOAD;
          end else begin
            fcnt_nxt = fcnt - 3'd1;
          end
        end
        TURN: begin
          if (fcnt == 3'd0) state_nxt = IDLE;
          else              fcnt_nxt  = fcnt - 3'd1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    case (state)
      WPRE, WDATA: t_nib = 4'b1111;
      WPOST:       t_nib = 4'b0011;
      default:     t_nib = 4'b0000;
    endcase
  end

  assign odt_ctrl   = (state == RDATA);
  assign rd_capture = (state == RDATA);
  assign busy       = (state != IDLE);
  assign update_ol  = (ph == 2'd1);
  assign phase      = ph;

endmodule

// File: doc/sdrio_dir_sched.md
SDRIO_DIR_SCHED -- requirements
Module: sdrio_dir_sched

Interface
REQ-001 Parameter PRE_FRAMES, default 1, range 0..1: number of write-preamble frames.
REQ-002 Parameter TURN_FRAMES, default 2, range 0..3: number of bus-turnaround frames after every burst.
REQ-003 Clocking and reset: reset rst, asynchronous, active-high; clock geclk_ol.
REQ-004 geclk_ol  in  1  fast serializer clock; frame = 4 cycles.
REQ-005 rst  in  1  async active-high reset.
REQ-006 wr_req  in  1  write requester level request.
REQ-007 wr_len  in  3  write burst length minus one, in frames.
REQ-008 rd_req  in  1  read requester level request.
REQ-009 rd_len  in  3  read burst length minus one, in frames.
REQ-010 wr_gnt  out  1  one-cycle write grant pulse.
REQ-011 rd_gnt  out  1  one-cycle read grant pulse.
REQ-012 t_nib  out  4  per-slot output enable for the 4:1 IO cell; 1 = drive pad.
REQ-013 odt_ctrl  out  1  on-die termination enable.
REQ-014 rd_capture  out  1  marks frames whose captured read nibble is valid.
REQ-015 update_ol  out  1  serializer load strobe.
REQ-016 phase  out  2  current slot index within frame.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 Phase counter ph SHALL be 0 in the first cycle after reset release, then increment modulo 4 every cycle; phase = ph.
REQ-019 update_ol SHALL be 1 exactly when ph==1.
REQ-020 All state transitions and grants SHALL occur only on the clock edge ending a cycle with ph==3; new state is therefore visible from ph==0.
REQ-021 States: IDLE, WPRE, WDATA, WPOST, RDATA, TURN.
REQ-022 IDLE, one request at ph==3: grant it; both requests: grant the direction opposite to last_dir; last_dir is updated to the granted direction.
REQ-023 Grant pulse SHALL be asserted during the ph==3 cycle in which the decision is made; wr_len/rd_len SHALL be sampled in that cycle.
REQ-024 Requester SHALL hold req until gnt and drop it the cycle after; a request withdrawn before gnt SHALL be ignored without side effects.
REQ-025 Write grant -> WPRE when PRE_FRAMES==1, else WDATA; read grant -> RDATA.
REQ-026 WPRE lasts 1 frame, then WDATA.
REQ-027 WDATA and RDATA SHALL last len+1 frames via a 3-bit frame counter loaded with len at grant and decremented at each frame end; exit when the counter is 0 at frame end.
REQ-028 WDATA -> WPOST (1 frame); WPOST and RDATA -> TURN when TURN_FRAMES>0, else IDLE.
REQ-029 TURN SHALL last TURN_FRAMES frames, then IDLE.
REQ-030 Requests arriving while busy SHALL NOT be granted until the state is IDLE at a ph==3 edge.
REQ-031 t_nib SHALL be 4'b1111 in WPRE and WDATA, 4'b0011 in WPOST, 4'b0000 otherwise.
REQ-032 odt_ctrl and rd_capture SHALL be 1 only in RDATA.
REQ-033 All outputs SHALL be decoded from registered state only; no combinational path from inputs to outputs except wr_gnt/rd_gnt, which may depend on the req inputs.
REQ-034 The frame counter SHALL NOT wrap; len=7 yields exactly 8 frames.

Reset
REQ-035 While rst is high: state=IDLE, ph=0, frame counter=0, last_dir=read (write wins the first tie); all outputs 0 except phase=0.
REQ-036 rst asserted mid-burst SHALL force the reset values immediately; no grant pulses or enables SHALL persist, and in-progress bursts are discarded.

Verification
REQ-037 Reset release, no requests -> update_ol high on cycles 1, 5, 9, ...; busy=0; t_nib=0000 throughout.
REQ-038 PRE_FRAMES=1, TURN_FRAMES=2; wr_req from cycle 0 with wr_len=1 -> wr_gnt at cycle 3; t_nib=1111 cycles 4-15; t_nib=0011 cycles 16-19; TURN cycles 20-27; busy=0 from cycle 28.
REQ-039 rd_req with rd_len=0 -> rd_gnt at ph==3; odt_ctrl=rd_capture=1 for exactly 4 cycles; t_nib stays 0000.
REQ-040 wr_req and rd_req held together from reset -> grants alternate write, read, write; each grant is separated by the burst plus TURN frames.
REQ-041 rst pulsed during WDATA -> same-cycle t_nib=0000 and busy=0; ph restarts at 0 after release.
REQ-042 len=7, TURN_FRAMES=0, PRE_FRAMES=0 write -> exactly 32 cycles of t_nib=1111, then 4 cycles of 0011, then IDLE.
